// File: rtl/bist_sched_pkg.sv
// Shared types and constants for the BIST run scheduler.
package bist_sched_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RUN_BICS   = 3'd1,
    GAP_BICS   = 3'd2,
    RUN_STRAIT = 3'd3,
    GAP_STRAIT = 3'd4,
    REPORT     = 3'd5
  } state_t;

  localparam logic [1:0] SEL_BOTH        = 2'b00;
  localparam logic [1:0] SEL_BICS        = 2'b01;
  localparam logic [1:0] SEL_STRAIT      = 2'b10;
  localparam logic [1:0] STRAIT_MODE_RST = 2'b01;

endpackage

// File: rtl/bist_engine_slot.sv
// One engine slot: start level, latency counter with watchdog/saturation, result latch.
// Watchdog compare is compiled in only when BIST_SCHED_WATCHDOG_EN is defined.
module bist_engine_slot #(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 run_active,
  input  logic                 gap_active,
  input  logic                 run_next,
  input  logic                 eng_done,
  input  logic                 eng_error,
  output logic                 start,
  output logic [CNT_WIDTH-1:0] cycles,
  output logic                 fail,
  output logic                 run_exit_c,
  output logic                 gap_exit_c,
  output logic                 wd_hit_c
);

  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
`ifdef BIST_SCHED_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic [CNT_WIDTH-1:0] cnt;
  logic                 at_limit;
  logic                 run_wd;
  logic                 gap_wd;

  // Phase exit decode; done takes priority over the watchdog in RUN.
  always_comb begin
    at_limit   = WD_EN && (cnt == CNT_LIMIT);
    run_wd     = run_active && !eng_done && at_limit;
    gap_wd     = gap_active && eng_done && at_limit;
    run_exit_c = run_active && (eng_done || at_limit);
    gap_exit_c = gap_active && (!eng_done || at_limit);
    wd_hit_c   = run_wd || gap_wd;
  end

  // Counter restarts at 0 on every phase entry and idles at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      start  <= 1'b0;
      cnt    <= '0;
      cycles <= '0;
      fail   <= 1'b0;
    end else begin
      start <= run_next;
      if ((run_active && !run_exit_c) || (gap_active && !gap_exit_c))
        cnt <= (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);
      else
        cnt <= '0;

      if (clear) begin
        cycles <= '0;
        fail   <= 1'b0;
      end else if (run_active && eng_done) begin
        cycles <= cnt;
        fail   <= eng_error;
      end else if (run_wd) begin
        cycles <= CNT_LIMIT;
        fail   <= 1'b1;
      end else if (gap_wd) begin
        fail <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bist_run_scheduler.sv
// Sequences BICS and STRAIT self-test engines on the shared array, one at a time.
// BIST_SCHED_WATCHDOG_EN enables the per-phase watchdog; otherwise timeout stays 0.
module bist_run_scheduler
  import bist_sched_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [1:0]           sel,
  input  logic [1:0]           strait_mode_cfg,
  output logic                 bics_start,
  input  logic                 bics_done,
  input  logic                 bics_error,
  output logic                 strait_en,
  output logic [1:0]           strait_bist_mode,
  input  logic                 strait_done,
  input  logic                 strait_error,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] bics_cycles,
  output logic [CNT_WIDTH-1:0] strait_cycles,
  output logic                 bics_fail,
  output logic                 strait_fail,
  output logic                 timeout
);

  state_t     state, state_next;
  logic [1:0] sel_q;
  logic       accept;
  logic       bics_run_exit, bics_gap_exit, bics_wd;
  logic       strait_run_exit, strait_gap_exit, strait_wd;

  // Next-state: the FSM only chooses slot order; slots report their own exits.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          accept     = 1'b1;
          state_next = (sel == SEL_STRAIT) ? RUN_STRAIT : RUN_BICS;
        end
      end
      RUN_BICS:   if (bics_run_exit) state_next = GAP_BICS;
      GAP_BICS:   if (bics_gap_exit) state_next = (sel_q == SEL_BICS) ? REPORT : RUN_STRAIT;
      RUN_STRAIT: if (strait_run_exit) state_next = GAP_STRAIT;
      GAP_STRAIT: if (strait_gap_exit) state_next = REPORT;
      REPORT:     state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      sel_q            <= SEL_BOTH;
      strait_bist_mode <= STRAIT_MODE_RST;
      busy             <= 1'b0;
      done             <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == REPORT);
      if (accept) begin
        sel_q            <= sel;
        strait_bist_mode <= strait_mode_cfg;
        timeout          <= 1'b0;
      end else begin
`ifdef BIST_SCHED_WATCHDOG_EN
        timeout <= timeout || bics_wd || strait_wd;
`else
        timeout <= 1'b0;
`endif
      end
    end
  end

  bist_engine_slot #(
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_bics_slot (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .run_active (state == RUN_BICS),
    .gap_active (state == GAP_BICS),
    .run_next   (state_next == RUN_BICS),
    .eng_done   (bics_done),
    .eng_error  (bics_error),
    .start      (bics_start),
    .cycles     (bics_cycles),
    .fail       (bics_fail),
    .run_exit_c (bics_run_exit),
    .gap_exit_c (bics_gap_exit),
    .wd_hit_c   (bics_wd)
  );

  bist_engine_slot #(
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_strait_slot (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .run_active (state == RUN_STRAIT),
    .gap_active (state == GAP_STRAIT),
    .run_next   (state_next == RUN_STRAIT),
    .eng_done   (strait_done),
    .eng_error  (strait_error),
    .start      (strait_en),
    .cycles     (strait_cycles),
    .fail       (strait_fail),
    .run_exit_c (strait_run_exit),
    .gap_exit_c (strait_gap_exit),
    .wd_hit_c   (strait_wd)
  );

`ifndef BIST_SCHED_WATCHDOG_EN
  logic unused_wd;
  assign unused_wd = bics_wd ^ strait_wd;
`endif

endmodule
